// File: rtl/sram_ctrl.sv
// Asynchronous-SRAM controller: one access per request, SETUP / ACTIVE / DONE
// sequencing over NCHIP 16-bit chips, all board-facing pins registered.
module sram_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 2,
  parameter int COMMON_CTRL = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W/8-1:0]    be,
  input  logic [DATA_W-1:0]      wdata,
  output logic                   ack,
  output logic [DATA_W-1:0]      rdata,
  output logic                   busy,
  output logic [ADDR_W-1:0]      ram_addr,
  input  logic [DATA_W-1:0]      ram_data_in,
  output logic [DATA_W-1:0]      ram_data_out,
  output logic                   ram_data_oe,
  output logic [DATA_W/16-1:0]   ram_ce_n,
  output logic [DATA_W/16-1:0]   ram_ub_n,
  output logic [DATA_W/16-1:0]   ram_lb_n,
  output logic [DATA_W/16-1:0]   ram_we_n,
  output logic [DATA_W/16-1:0]   ram_oe_n
);

  localparam int         NCHIP     = DATA_W / 16;
  localparam int         BE_W      = DATA_W / 8;
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACTIVE, S_DONE} state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [NCHIP-1:0]  sel_in;
  logic [NCHIP-1:0]  sel_q;

  // A chip is selected when either of its two byte lanes is enabled.
  function automatic logic [NCHIP-1:0] chip_sel(input logic [BE_W-1:0] b);
    logic [NCHIP-1:0] s;
    for (int i = 0; i < NCHIP; i++) s[i] = b[2*i] | b[2*i+1];
    return s;
  endfunction

  function automatic logic [NCHIP-1:0] lane_n(input logic [BE_W-1:0] b, input logic upper);
    logic [NCHIP-1:0] s;
    for (int i = 0; i < NCHIP; i++) s[i] = ~b[2*i + (upper ? 1 : 0)];
    return s;
  endfunction

  // Boards with one shared /WE and /OE pull the line low if any chip needs it.
  function automatic logic [NCHIP-1:0] share(input logic [NCHIP-1:0] v);
    return (COMMON_CTRL != 0) ? {NCHIP{&v}} : v;
  endfunction

  function automatic logic [DATA_W-1:0] byte_mask(input logic [BE_W-1:0] b);
    logic [DATA_W-1:0] m;
    for (int k = 0; k < BE_W; k++) m[8*k +: 8] = {8{b[k]}};
    return m;
  endfunction

  assign sel_in = chip_sel(be);
  assign sel_q  = chip_sel(be_q);
  assign busy   = (state != S_IDLE);

  // NOTE: all state and pin registers use non-blocking assignments and a
  // synchronous reset, so every board strobe changes only on a clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      ack          <= 1'b0;
      rdata        <= '0;
      ram_addr     <= '0;
      ram_data_out <= '0;
      ram_data_oe  <= 1'b0;
      ram_ce_n     <= '1;
      ram_ub_n     <= '1;
      ram_lb_n     <= '1;
      ram_we_n     <= '1;
      ram_oe_n     <= '1;
    end else begin
      ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            state       <= S_SETUP;
            we_q        <= we;
            be_q        <= be;
            ram_addr    <= addr;
            ram_data_oe <= we;
            if (we) ram_data_out <= wdata;
            ram_ce_n    <= ~sel_in;
            ram_ub_n    <= lane_n(be, 1'b1);
            ram_lb_n    <= lane_n(be, 1'b0);
            ram_oe_n    <= we ? '1 : share(~sel_in);
          end
        end
        S_SETUP: begin
          state    <= S_ACTIVE;
          wait_cnt <= '0;
          if (we_q) ram_we_n <= share(~sel_q);
        end
        S_ACTIVE: begin
          if (wait_cnt == LAST_WAIT) begin
            state    <= S_DONE;
            wait_cnt <= '0;
            ack      <= 1'b1;
            ram_ce_n <= '1;
            ram_ub_n <= '1;
            ram_lb_n <= '1;
            ram_we_n <= '1;
            ram_oe_n <= '1;
            if (!we_q) rdata <= ram_data_in & byte_mask(be_q);
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_DONE: begin
          // Write data is held through DONE; the bus is released on entry to IDLE.
          state       <= S_IDLE;
          ram_data_oe <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed vector table, randomized accesses
// against a cycle-level reference model, and multi-cycle corner sequences.
module tb_sram_ctrl;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // Main instance: DATA_W=32, WAIT_STATES=2, COMMON_CTRL=0
  logic        req, we;
  logic [17:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata, ram_data_in;
  logic        ack, busy, ram_data_oe;
  logic [31:0] rdata, ram_data_out;
  logic [17:0] ram_addr;
  logic [1:0]  ram_ce_n, ram_ub_n, ram_lb_n, ram_we_n, ram_oe_n;

  // Second instance: WAIT_STATES=0, COMMON_CTRL=1
  logic        d2_req, d2_we;
  logic [17:0] d2_addr;
  logic [3:0]  d2_be;
  logic [31:0] d2_wdata, d2_ram_data_in;
  logic        d2_ack, d2_busy, d2_ram_data_oe;
  logic [31:0] d2_rdata, d2_ram_data_out;
  logic [17:0] d2_ram_addr;
  logic [1:0]  d2_ram_ce_n, d2_ram_ub_n, d2_ram_lb_n, d2_ram_we_n, d2_ram_oe_n;

  sram_ctrl #(.ADDR_W(18), .DATA_W(32), .WAIT_STATES(WS), .COMMON_CTRL(0)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .ram_data_oe(ram_data_oe), .ram_ce_n(ram_ce_n),
    .ram_ub_n(ram_ub_n), .ram_lb_n(ram_lb_n), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n)
  );

  sram_ctrl #(.ADDR_W(18), .DATA_W(32), .WAIT_STATES(0), .COMMON_CTRL(1)) dut2 (
    .clk(clk), .reset(reset), .req(d2_req), .we(d2_we), .addr(d2_addr), .be(d2_be),
    .wdata(d2_wdata), .ack(d2_ack), .rdata(d2_rdata), .busy(d2_busy), .ram_addr(d2_ram_addr),
    .ram_data_in(d2_ram_data_in), .ram_data_out(d2_ram_data_out),
    .ram_data_oe(d2_ram_data_oe), .ram_ce_n(d2_ram_ce_n), .ram_ub_n(d2_ram_ub_n),
    .ram_lb_n(d2_ram_lb_n), .ram_we_n(d2_ram_we_n), .ram_oe_n(d2_ram_oe_n)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_rdata;

  typedef struct {
    logic        w;
    logic [3:0]  be;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [31:0] din;
    logic [1:0]  ce_n;
    logic [1:0]  ub_n;
    logic [1:0]  lb_n;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] sel_of(input logic [3:0] b);
    logic [1:0] s;
    for (int i = 0; i < 2; i++) s[i] = ((b >> (2 * i)) & 4'd3) != 4'd0;
    return s;
  endfunction

  function automatic logic [31:0] mask_of(input logic [3:0] b);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (b[k]) m = m | (32'hFF << (8 * k));
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete access on the main instance, starting from the IDLE cycle after
  // the previous DONE. Cycle c counts from the accept edge (c=1 is SETUP).
  task automatic run_txn(input logic w, input logic [3:0] b, input logic [17:0] a,
                         input logic [31:0] wd, input logic [31:0] din,
                         output logic [1:0] got_ce, output logic [1:0] got_ub,
                         output logic [1:0] got_lb, output logic [31:0] got_rdata);
    logic [1:0]  sel, exp_ce, exp_ub, exp_lb, exp_we, exp_oe;
    logic        strobing;
    step();
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_ack", 64'(ack), 64'(0));
    check("idle_data_oe", 64'(ram_data_oe), 64'(0));
    check("idle_ce_n", 64'(ram_ce_n), 64'(2'b11));
    req = 1'b1; we = w; be = b; addr = a; wdata = wd; ram_data_in = din;
    sel = sel_of(b);
    got_ce = 2'b11; got_ub = 2'b11; got_lb = 2'b11; got_rdata = '0;
    for (int c = 1; c <= WS + 3; c++) begin
      step();
      strobing = (c <= WS + 2);
      exp_ce = strobing ? ~sel : 2'b11;
      exp_ub = strobing ? ~{b[3], b[1]} : 2'b11;
      exp_lb = strobing ? ~{b[2], b[0]} : 2'b11;
      exp_we = (w && c >= 2 && strobing) ? ~sel : 2'b11;
      exp_oe = (!w && strobing) ? ~sel : 2'b11;
      check("ce_n", 64'(ram_ce_n), 64'(exp_ce));
      check("ub_n", 64'(ram_ub_n), 64'(exp_ub));
      check("lb_n", 64'(ram_lb_n), 64'(exp_lb));
      check("we_n", 64'(ram_we_n), 64'(exp_we));
      check("oe_n", 64'(ram_oe_n), 64'(exp_oe));
      check("data_oe", 64'(ram_data_oe), 64'(w));
      check("ack", 64'(ack), 64'(c == WS + 3));
      check("busy", 64'(busy), 64'(1));
      check("ram_addr", 64'(ram_addr), 64'(a));
      if (w) check("ram_data_out", 64'(ram_data_out), 64'(wd));
      if (c == 1) begin
        got_ce = ram_ce_n; got_ub = ram_ub_n; got_lb = ram_lb_n;
      end
      if (c == WS + 3) begin
        if (!w) model_rdata = din & mask_of(b);
        check("rdata", 64'(rdata), 64'(model_rdata));
        got_rdata = rdata;
        req = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  g_ce, g_ub, g_lb;
    logic [31:0] g_rd;

    vecs[0] = '{1'b1, 4'b1111, 18'h00123, 32'hDEADBEEF, 32'h0,        2'b00, 2'b00, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 4'b0011, 18'h3ABCD, 32'h0,        32'hCAFEF00D, 2'b10, 2'b10, 2'b10, 32'h0000F00D};
    vecs[2] = '{1'b1, 4'b0100, 18'h00040, 32'h12345678, 32'h0,        2'b01, 2'b11, 2'b01, 32'h0000F00D};
    vecs[3] = '{1'b0, 4'b0000, 18'h1FFFF, 32'h0,        32'hFFFFFFFF, 2'b11, 2'b11, 2'b11, 32'h0};
    vecs[4] = '{1'b0, 4'b1001, 18'h00777, 32'h0,        32'h89ABCDEF, 2'b00, 2'b01, 2'b10, 32'h890000EF};
    vecs[5] = '{1'b1, 4'b1000, 18'h20000, 32'hA5A5A5A5, 32'h0,        2'b01, 2'b01, 2'b11, 32'h890000EF};

    req = 0; we = 0; addr = '0; be = '0; wdata = '0; ram_data_in = '0;
    d2_req = 0; d2_we = 0; d2_addr = '0; d2_be = '0; d2_wdata = '0; d2_ram_data_in = '0;
    model_rdata = '0;

    // Reset state
    reset = 1'b1;
    step(); step();
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_data_oe", 64'(ram_data_oe), 64'(0));
    check("rst_addr", 64'(ram_addr), 64'(0));
    check("rst_data_out", 64'(ram_data_out), 64'(0));
    check("rst_strobes", 64'({ram_ce_n, ram_ub_n, ram_lb_n, ram_we_n, ram_oe_n}), 64'(10'h3FF));
    check("rst_d2_strobes", 64'({d2_ram_ce_n, d2_ram_we_n, d2_ram_oe_n}), 64'(6'h3F));
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].w, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].din,
              g_ce, g_ub, g_lb, g_rd);
      check($sformatf("vec%0d_ce_n", i), 64'(g_ce), 64'(vecs[i].ce_n));
      check($sformatf("vec%0d_ub_n", i), 64'(g_ub), 64'(vecs[i].ub_n));
      check($sformatf("vec%0d_lb_n", i), 64'(g_lb), 64'(vecs[i].lb_n));
      check($sformatf("vec%0d_rdata", i), 64'(g_rd), 64'(vecs[i].rdata));
    end

    // Randomized accesses against the reference model
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(0, 1)), 4'($urandom), 18'($urandom), $urandom, $urandom,
              g_ce, g_ub, g_lb, g_rd);
    end

    // Read then write with req held high across the ack cycle
    step();
    req = 1'b1; we = 1'b0; be = 4'b1111; addr = 18'h00ABC; ram_data_in = 32'h11223344;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      step();
      check($sformatf("b2b_ack_c%0d", cyc), 64'(ack), 64'(cyc == 5 || cyc == 11));
      check($sformatf("b2b_data_oe_c%0d", cyc), 64'(ram_data_oe), 64'(cyc >= 7 && cyc <= 11));
      check($sformatf("b2b_busy_c%0d", cyc), 64'(busy), 64'(cyc != 6));
      if (cyc == 5) begin
        check("b2b_rdata", 64'(rdata), 64'(32'h11223344));
        we = 1'b1; addr = 18'h00DEF; wdata = 32'h55667788;
      end
      if (cyc == 7) check("b2b_wr_addr", 64'(ram_addr), 64'(18'h00DEF));
    end
    req = 1'b0;
    model_rdata = 32'h11223344;

    // Reset during ACTIVE of a write: access aborted, no ack
    step();
    req = 1'b1; we = 1'b1; be = 4'b1111; addr = 18'h01234; wdata = 32'hFEEDFACE;
    step(); step(); step();
    reset = 1'b1; req = 1'b0;
    step();
    check("rstmid_strobes", 64'({ram_ce_n, ram_ub_n, ram_lb_n, ram_we_n, ram_oe_n}), 64'(10'h3FF));
    check("rstmid_data_oe", 64'(ram_data_oe), 64'(0));
    check("rstmid_ack", 64'(ack), 64'(0));
    check("rstmid_busy", 64'(busy), 64'(0));
    check("rstmid_addr", 64'(ram_addr), 64'(0));
    reset = 1'b0;
    model_rdata = '0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      step();
      check("rstmid_no_ack", 64'(ack), 64'(0));
    end
    run_txn(1'b0, 4'b1111, 18'h00042, 32'h0, 32'h0BADC0DE, g_ce, g_ub, g_lb, g_rd);
    check("rstmid_read_rdata", 64'(g_rd), 64'(32'h0BADC0DE));

    // WAIT_STATES=0, shared /WE: write be 0011
    d2_req = 1'b1; d2_we = 1'b1; d2_be = 4'b0011; d2_addr = 18'h00300; d2_wdata = 32'h0000BEEF;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      step();
      check($sformatf("ws0_we_n_c%0d", cyc), 64'(d2_ram_we_n), 64'(cyc == 2 ? 2'b00 : 2'b11));
      check($sformatf("ws0_ce_n_c%0d", cyc), 64'(d2_ram_ce_n), 64'(cyc <= 2 ? 2'b10 : 2'b11));
      check($sformatf("ws0_ack_c%0d", cyc), 64'(d2_ack), 64'(cyc == 3));
      check($sformatf("ws0_data_oe_c%0d", cyc), 64'(d2_ram_data_oe), 64'(cyc <= 3));
      check($sformatf("ws0_oe_n_c%0d", cyc), 64'(d2_ram_oe_n), 64'(2'b11));
      if (cyc == 3) d2_req = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
